// File: rtl/upsample_pkg.sv
// rtl/upsample_pkg.sv - shared types, default widths and helpers for the upsample scheduler
package upsample_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int DIV_W_DEF   = 16;
  localparam int RATIO_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2
  } state_t;

  // A ratio of 0 has no meaningful frame, so it runs as plain pass-through (L=1).
  function automatic logic [RATIO_W_DEF-1:0] clamp_ratio(input logic [RATIO_W_DEF-1:0] r);
    return (r == '0) ? RATIO_W_DEF'(1) : r;
  endfunction

endpackage

// File: rtl/upsample_scheduler_if.sv
// rtl/upsample_scheduler_if.sv - sample input handshake and zero-stuffed output stream
interface upsample_scheduler_if
  import upsample_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RATIO_W = RATIO_W_DEF
);
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic [RATIO_W-1:0] phase;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid, phase
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid, phase
  );
endinterface

// File: rtl/upsample_scheduler_rate_tick_gen.sv
// rtl/upsample_scheduler_rate_tick_gen.sv - loadable down-counter that ticks once per reload+1 cycles
module rate_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] reload,
  output logic             tick
);
  logic [DIV_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load || (en && count == '0)) begin
      count <= reload;
    end else if (en) begin
      count <= count - DIV_W'(1);
    end
  end

  assign tick = en && (count == '0);
endmodule

// File: rtl/upsample_scheduler.sv
// rtl/upsample_scheduler.sv - zero-stuffing interpolator sequencer: fetch, output-rate tick, phase, underrun
module upsample_scheduler
  import upsample_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int RATIO_W = RATIO_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic [RATIO_W-1:0]  ratio,
  upsample_scheduler_if.slave bus,
  output logic                underrun,
  output logic [CNT_W-1:0]    underrun_cnt,
  output logic                busy
);
  state_t             state;
  logic [DIV_W-1:0]   div_r;
  logic [RATIO_W-1:0] l_r;
  logic [RATIO_W-1:0] phase_r;
  logic [RATIO_W-1:0] phase_last;
  logic [DATA_W-1:0]  hold;
  logic               hold_full;

  logic tick;
  logic accept;
  logic frame_end;
  logic consume;

  assign accept    = bus.in_valid && bus.in_ready;
  assign frame_end = tick && (phase_r == l_r - RATIO_W'(1));
  assign consume   = tick && (phase_r == '0) && hold_full;

  // New clk_div takes effect from the first period of the following frame.
  rate_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (state == FETCH && accept),
    .en     (state == RUN),
    .reload (frame_end ? clk_div : div_r),
    .tick   (tick)
  );

  assign bus.in_ready  = (state == FETCH) || (state == RUN && !hold_full);
  assign bus.out_valid = tick;
  assign bus.out_data  = consume ? hold : '0;
  assign bus.phase     = tick ? phase_r : phase_last;
  assign underrun      = tick && (phase_r == '0) && !hold_full;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_r        <= '0;
      l_r          <= RATIO_W'(1);
      phase_r      <= '0;
      phase_last   <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            div_r <= clk_div;
            l_r   <= clamp_ratio(ratio);
            state <= FETCH;
          end
        end
        FETCH: begin
          if (accept) begin
            hold      <= bus.in_data;
            hold_full <= 1'b1;
            phase_r   <= '0;
            state     <= RUN;
          end else if (!enable) begin
            state <= IDLE;
          end
        end
        RUN: begin
          // A sample landing on a starved phase-0 tick is kept for the next frame.
          if (accept) begin
            hold      <= bus.in_data;
            hold_full <= 1'b1;
          end else if (consume) begin
            hold_full <= 1'b0;
          end
          if (tick) begin
            phase_last <= phase_r;
            phase_r    <= frame_end ? '0 : phase_r + RATIO_W'(1);
          end
          if (underrun && underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + CNT_W'(1);
          end
          if (frame_end) begin
            div_r <= clk_div;
            l_r   <= clamp_ratio(ratio);
            if (!enable) begin
              state     <= IDLE;
              hold_full <= 1'b0;
              phase_r   <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_upsample_scheduler.sv
// tb/tb_upsample_scheduler.sv - table-driven checks of tick timing, phase, data and underrun behaviour
module tb_upsample_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] clk_div = '0;
  logic [3:0]  ratio = '0;
  logic        underrun;
  logic [3:0]  underrun_cnt;
  logic        busy;

  upsample_scheduler_if #(.DATA_W(32), .RATIO_W(4)) bus ();

  upsample_scheduler #(.DATA_W(32), .DIV_W(16), .RATIO_W(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clk_div      (clk_div),
    .ratio        (ratio),
    .bus          (bus),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gap;
    int ph;
    int data;
    bit und;
    bit feed;
  } vec_t;

  vec_t tbl [64];
  int   nt = 0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_tick_cyc = 0;
  int   last_acc_cyc = 0;
  int   seq = 1;
  int   budget = 0;
  bit   acc_seen = 0;
  bit   dead = 0;

  task automatic add(input int gap, input int ph, input int data, input bit und, input bit feed);
    tbl[nt] = '{gap: gap, ph: ph, data: data, und: und, feed: feed};
    nt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; the upstream source hands out sample seq*0x11 on each accept.
  task automatic step();
    bit acc;
    acc = bus.in_valid && bus.in_ready;
    @(negedge clk);
    cyc++;
    if (acc) begin
      acc_seen     = 1;
      last_acc_cyc = cyc - 1;
      seq++;
      bus.in_data  = 32'(seq * 32'h11);
      if (budget > 0) budget--;
    end
    bus.in_valid = (budget > 0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    enable       = 1'b0;
    clk_div      = '0;
    ratio        = '0;
    budget       = 0;
    seq          = 1;
    bus.in_data  = 32'h11;
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic start(input int div, input int rat);
    if (dead) return;
    clk_div      = 16'(div);
    ratio        = 4'(rat);
    bus.in_valid = (budget > 0);
    enable       = 1'b1;
    acc_seen     = 0;
    for (int n = 0; n < 10 && !acc_seen; n++) step();
    if (!acc_seen) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: no accept within 10 cycles, expected one");
      dead = 1;
    end
    last_tick_cyc = last_acc_cyc;
  endtask

  task automatic wait_tick(output bit ok);
    int n;
    n  = 0;
    ok = 0;
    if (dead) return;
    while (bus.out_valid !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (bus.out_valid === 1'b1) begin
      ok = 1;
    end else begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no out_valid after %0d cycles, expected a tick", n);
      dead = 1;
    end
  endtask

  task automatic run_ticks(input int first, input int last);
    bit ok;
    for (int i = first; i <= last; i++) begin
      wait_tick(ok);
      if (!ok) return;
      chk($sformatf("t%0d.gap", i), 32'(cyc - last_tick_cyc), 32'(tbl[i].gap));
      chk($sformatf("t%0d.phase", i), {28'd0, bus.phase}, 32'(tbl[i].ph));
      chk($sformatf("t%0d.data", i), bus.out_data, 32'(tbl[i].data));
      chk($sformatf("t%0d.underrun", i), {31'd0, underrun}, {31'd0, tbl[i].und});
      last_tick_cyc = cyc;
      if (tbl[i].feed) begin
        budget       = 1;
        bus.in_valid = 1'b1;
      end
      step();
    end
  endtask

  task automatic quiet(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.out_valid !== 1'b0) bad++;
      step();
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    bit ok;
    int pulses;

    // 0..12: clk_div=999, L=6, source always valid
    for (int i = 0; i < 13; i++) add(1000, i % 6, (i % 6 == 0) ? (i / 6 + 1) * 32'h11 : 0, 0, 0);
    // 13..31: clk_div=3, L=6, one sample then starved; sample fed on the second starved phase-0 tick
    for (int i = 0; i < 19; i++)
      add(4, i % 6, (i == 0) ? 32'h11 : (i == 18) ? 32'h22 : 0, (i == 6 || i == 12), (i == 12));
    // 32..41: ratio 6 -> 3 after phase 2
    add(4, 0, 32'h11, 0, 0); add(4, 1, 0, 0, 0); add(4, 2, 0, 0, 0);
    add(4, 3, 0, 0, 0);      add(4, 4, 0, 0, 0); add(4, 5, 0, 0, 0);
    add(4, 0, 32'h22, 0, 0); add(4, 1, 0, 0, 0); add(4, 2, 0, 0, 0);
    add(4, 0, 32'h33, 0, 0);
    // 42..49: disable after phase 3, then restart (0x22 was discarded)
    add(4, 0, 32'h11, 0, 0); add(4, 1, 0, 0, 0); add(4, 2, 0, 0, 0); add(4, 3, 0, 0, 0);
    add(4, 4, 0, 0, 0);      add(4, 5, 0, 0, 0);
    add(4, 0, 32'h33, 0, 0); add(4, 1, 0, 0, 0);
    // 50..53: ratio=0 acts as L=1
    add(4, 0, 32'h11, 0, 0); add(4, 0, 32'h22, 0, 0); add(4, 0, 32'h33, 0, 0); add(4, 0, 32'h44, 0, 0);
    // 54..59: clk_div=0, L=1: sample / starved alternate at full rate
    add(1, 0, 32'h11, 0, 0); add(1, 0, 0, 1, 0); add(1, 0, 32'h22, 0, 0);
    add(1, 0, 0, 1, 0);      add(1, 0, 32'h33, 0, 0); add(1, 0, 0, 1, 0);

    do_reset();
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.out_data", bus.out_data, 32'd0);
    chk("rst.phase", {28'd0, bus.phase}, 32'd0);
    chk("rst.underrun", {31'd0, underrun}, 32'd0);
    chk("rst.underrun_cnt", {28'd0, underrun_cnt}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);

    budget = 1000; start(999, 6); run_ticks(0, 12);
    chk("basic.underrun_cnt", {28'd0, underrun_cnt}, 32'd0);

    do_reset(); budget = 1; start(3, 6); run_ticks(13, 19);
    chk("starve1.underrun_cnt", {28'd0, underrun_cnt}, 32'd1);
    run_ticks(20, 31);
    chk("starve2.underrun_cnt", {28'd0, underrun_cnt}, 32'd2);

    do_reset(); budget = 1000; start(3, 6); run_ticks(32, 34);
    ratio = 4'd3;
    run_ticks(35, 41);

    do_reset(); budget = 1000; start(3, 6); run_ticks(42, 45);
    enable = 1'b0;
    run_ticks(46, 47);
    chk("disable.busy", {31'd0, busy}, 32'd0);
    chk("disable.in_ready", {31'd0, bus.in_ready}, 32'd0);
    quiet("disable.quiet", 8);
    start(3, 6); run_ticks(48, 49);

    do_reset(); budget = 1000; start(3, 0); run_ticks(50, 53);

    do_reset(); budget = 1000; start(0, 0); run_ticks(54, 59);
    chk("fast.underrun_cnt", {28'd0, underrun_cnt}, 32'd3);

    do_reset(); budget = 1; start(0, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (underrun === 1'b1) pulses++;
      step();
    end
    chk("sat.pulses", 32'(pulses), 32'd19);
    chk("sat.underrun_cnt", {28'd0, underrun_cnt}, 32'hF);

    do_reset(); budget = 1000; start(3, 6); run_ticks(42, 45);
    wait_tick(ok);
    if (ok) chk("midrst.phase_before", {28'd0, bus.phase}, 32'd4);
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst.out_data", bus.out_data, 32'd0);
    chk("midrst.phase", {28'd0, bus.phase}, 32'd0);
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.in_ready", {31'd0, bus.in_ready}, 32'd0);
    do_reset();
    budget = 1000;
    bus.in_valid = 1'b1;
    quiet("midrst.quiet", 10);
    chk("midrst.idle_busy", {31'd0, busy}, 32'd0);
    start(3, 0); run_ticks(50, 53);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
